// File: rtl/cpu_bus_map.sv
// ============================================================================
// Module   : cpu_bus_map
// Purpose  : NES CPU-side address decoder, work RAM, controller ports and
//            registered read-return stage. Optional open-bus latch under
//            CPU_BUS_OPEN_BUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_map #(
  parameter int RAM_AW = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        ppu_sel_o,
  output logic [2:0]  ppu_reg_o,
  input  logic [7:0]  ppu_data_i,
  output logic        apu_sel_o,
  output logic        cart_sel_o,
  input  logic [7:0]  cart_data_i,
  input  logic [7:0]  ctrl1_buttons_i,
  input  logic [7:0]  ctrl2_buttons_i
);

  logic is_ram, is_ppu, is_io, is_ctrl1, is_ctrl2, is_cart;
  logic rd, wr, ram_we;

  assign wr       = cpu_rw_i;
  assign rd       = ~cpu_rw_i;
  assign is_ram   = (cpu_address_i[15:13] == 3'b000);
  assign is_ppu   = (cpu_address_i[15:13] == 3'b001);
  assign is_io    = (cpu_address_i[15:5] == 11'h200);
  assign is_ctrl1 = (cpu_address_i == 16'h4016);
  assign is_ctrl2 = (cpu_address_i == 16'h4017);
  assign is_cart  = ~is_ram & ~is_ppu & ~is_io;

  assign ppu_sel_o  = is_ppu;
  assign ppu_reg_o  = cpu_address_i[2:0];
  assign cart_sel_o = is_cart;
  assign apu_sel_o  = wr & is_io & ((cpu_address_i[4:0] <= 5'h13) ||
                                    (cpu_address_i[4:0] == 5'h15) ||
                                    (cpu_address_i[4:0] == 5'h17));

  // Work RAM: no reset so it maps onto block RAM; writes blocked while in reset.
  logic [7:0] ram [0:(1<<RAM_AW)-1];
  logic [7:0] ram_q;

  assign ram_we = rst_n & wr & is_ram;

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[cpu_address_i[RAM_AW-1:0]] <= cpu_data_i;
    if (rd)
      ram_q <= ram[cpu_address_i[RAM_AW-1:0]];
  end

  logic       ram_sel_q;
  logic [7:0] other_q;
  logic       strobe_q;
  logic [7:0] shift1, shift2;
  logic [7:0] open_bus;
  logic [7:0] rd_byte;
  logic       ctrl1_bit, ctrl2_bit;

`ifdef CPU_BUS_OPEN_BUS_EN
  logic [7:0] ob_q;
  logic       ob_from_ram_q;

  // A RAM read only produces its byte after the edge, so the latch tracks it through ram_q.
  assign open_bus = ob_from_ram_q ? ram_q : ob_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_q          <= 8'h00;
      ob_from_ram_q <= 1'b0;
    end else begin
      ob_from_ram_q <= rd & is_ram;
      if (wr)
        ob_q <= cpu_data_i;
      else if (!is_ram)
        ob_q <= rd_byte;
    end
  end
`else
  assign open_bus = 8'h00;
`endif

  // With strobe held the port reports live A rather than a stale reload.
  assign ctrl1_bit = strobe_q ? ctrl1_buttons_i[0] : shift1[0];
  assign ctrl2_bit = strobe_q ? ctrl2_buttons_i[0] : shift2[0];

  always_comb begin
    rd_byte = open_bus;
    if (is_ppu)
      rd_byte = ppu_data_i;
    else if (is_ctrl1)
      rd_byte = {open_bus[7:1], ctrl1_bit};
    else if (is_ctrl2)
      rd_byte = {open_bus[7:1], ctrl2_bit};
    else if (is_cart)
      rd_byte = cart_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_sel_q <= 1'b0;
      other_q   <= 8'h00;
      strobe_q  <= 1'b0;
      shift1    <= 8'h00;
      shift2    <= 8'h00;
    end else begin
      if (rd) begin
        ram_sel_q <= is_ram;
        other_q   <= is_ram ? 8'h00 : rd_byte;
      end
      if (wr && is_ctrl1)
        strobe_q <= cpu_data_i[0];
      if (strobe_q) begin
        shift1 <= ctrl1_buttons_i;
        shift2 <= ctrl2_buttons_i;
      end else begin
        if (rd && is_ctrl1)
          shift1 <= {1'b1, shift1[7:1]};
        if (rd && is_ctrl2)
          shift2 <= {1'b1, shift2[7:1]};
      end
    end
  end

  assign cpu_data_o = ram_sel_q ? ram_q : other_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_map.sv
// ============================================================================
// Module   : tb_cpu_bus_map
// Purpose  : Directed self-checking bench for cpu_bus_map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_map;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ppu_sel;
  logic [2:0]  ppu_reg;
  logic [7:0]  ppu_data;
  logic        apu_sel;
  logic        cart_sel;
  logic [7:0]  cart_data;
  logic [7:0]  ctrl1;
  logic [7:0]  ctrl2;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_bus_map #(.RAM_AW(11)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_address_i   (addr),
    .cpu_rw_i        (rw),
    .cpu_data_i      (wdata),
    .cpu_data_o      (rdata),
    .ppu_sel_o       (ppu_sel),
    .ppu_reg_o       (ppu_reg),
    .ppu_data_i      (ppu_data),
    .apu_sel_o       (apu_sel),
    .cart_sel_o      (cart_sel),
    .cart_data_i     (cart_data),
    .ctrl1_buttons_i (ctrl1),
    .ctrl2_buttons_i (ctrl2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ob_exp(input logic [7:0] v);
`ifdef CPU_BUS_OPEN_BUS_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  // One bus cycle: drive on falling edge, commit on rising edge, return just after it.
  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    rw    = w;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_data_held: got %h expected 00", rdata); end
    n_checks++;
    if ({ppu_sel, apu_sel, cart_sel} !== 3'b000) begin n_fail++; $display("FAIL reset_selects: got %b expected 000", {ppu_sel, apu_sel, cart_sel}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl1_read: got %h expected 00", rdata); end
  endtask

  task automatic test_ram_mirror;
    cyc(16'h0123, 1'b1, 8'h5A);
    cyc(16'h0923, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h5A) begin n_fail++; $display("FAIL mirror_0923: got %h expected 5a", rdata); end
    cyc(16'h1123, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h5A) begin n_fail++; $display("FAIL mirror_1123: got %h expected 5a", rdata); end
    cyc(16'h1923, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h5A) begin n_fail++; $display("FAIL mirror_1923: got %h expected 5a", rdata); end
    cyc(16'h1FFF, 1'b1, 8'hA5);
    cyc(16'h07FF, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'hA5) begin n_fail++; $display("FAIL mirror_07ff: got %h expected a5", rdata); end
  endtask

  task automatic test_open_bus;
    cart_data = 8'h4A;
    cyc(16'h8000, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h4A) begin n_fail++; $display("FAIL cart_read: got %h expected 4a", rdata); end
    cyc(16'h4018, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== ob_exp(8'h4A)) begin n_fail++; $display("FAIL ob_after_cart: got %h expected %h", rdata, ob_exp(8'h4A)); end
    cyc(16'h0123, 1'b0, 8'h00);
    cyc(16'h4018, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== ob_exp(8'h5A)) begin n_fail++; $display("FAIL ob_after_ram: got %h expected %h", rdata, ob_exp(8'h5A)); end
    cyc(16'h4019, 1'b1, 8'h3C);
    n_checks++;
    if (apu_sel !== 1'b0) begin n_fail++; $display("FAIL apu_sel_4019: got %b expected 0", apu_sel); end
    cyc(16'h401F, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== ob_exp(8'h3C)) begin n_fail++; $display("FAIL ob_after_write: got %h expected %h", rdata, ob_exp(8'h3C)); end
  endtask

  task automatic test_controller;
    logic [9:0] seq;
    logic [7:0] upper;
    logic [7:0] exp_b;
    seq   = 10'b11_1000_0001;
    upper = ob_exp(8'hFE);
    ctrl1 = 8'h81;
    cyc(16'h4016, 1'b1, 8'h01);
    cyc(16'h4016, 1'b1, 8'hFE);
    for (int i = 0; i < 10; i++) begin
      cyc(16'h4016, 1'b0, 8'h00);
      exp_b = {upper[7:1], seq[i]};
      n_checks++;
      if (rdata !== exp_b) begin n_fail++; $display("FAIL ctrl1_read_%0d: got %h expected %h", i, rdata, exp_b); end
    end
  endtask

  task automatic test_strobe_held;
    cyc(16'h4016, 1'b1, 8'h01);
    ctrl1 = 8'h01;
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL strobe_live_a1: got %b expected 1", rdata[0]); end
    ctrl1 = 8'h00;
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b0) begin n_fail++; $display("FAIL strobe_live_a0: got %b expected 0", rdata[0]); end
    ctrl1 = 8'h01;
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL strobe_live_a1b: got %b expected 1", rdata[0]); end
    ctrl1 = 8'h02;
    ctrl2 = 8'h01;
    cyc(16'h4016, 1'b1, 8'h00);
    cyc(16'h4017, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL ctrl2_bit0: got %b expected 1", rdata[0]); end
    cyc(16'h4017, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b0) begin n_fail++; $display("FAIL ctrl2_bit1: got %b expected 0", rdata[0]); end
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b0) begin n_fail++; $display("FAIL ctrl1_indep_a: got %b expected 0", rdata[0]); end
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL ctrl1_indep_b: got %b expected 1", rdata[0]); end
    ctrl1 = 8'hFF;
    cyc(16'h4017, 1'b1, 8'h01);
    n_checks++;
    if (apu_sel !== 1'b1) begin n_fail++; $display("FAIL apu_sel_4017: got %b expected 1", apu_sel); end
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b0) begin n_fail++; $display("FAIL strobe_kept_after_4017: got %b expected 0", rdata[0]); end
    cyc(16'h4013, 1'b1, 8'h00);
    n_checks++;
    if (apu_sel !== 1'b1) begin n_fail++; $display("FAIL apu_sel_4013: got %b expected 1", apu_sel); end
    cyc(16'h4014, 1'b1, 8'h00);
    n_checks++;
    if (apu_sel !== 1'b0) begin n_fail++; $display("FAIL apu_sel_4014: got %b expected 0", apu_sel); end
    cyc(16'h4015, 1'b1, 8'h00);
    n_checks++;
    if (apu_sel !== 1'b1) begin n_fail++; $display("FAIL apu_sel_4015w: got %b expected 1", apu_sel); end
    cyc(16'h4015, 1'b0, 8'h00);
    n_checks++;
    if (apu_sel !== 1'b0) begin n_fail++; $display("FAIL apu_sel_4015r: got %b expected 0", apu_sel); end
    cyc(16'h4016, 1'b1, 8'h00);
    n_checks++;
    if (apu_sel !== 1'b0) begin n_fail++; $display("FAIL apu_sel_4016: got %b expected 0", apu_sel); end
  endtask

  task automatic test_decode;
    ppu_data = 8'hC3;
    cyc(16'h3FFF, 1'b0, 8'h00);
    n_checks++;
    if ({ppu_sel, ppu_reg, cart_sel} !== 5'b1_111_0) begin n_fail++; $display("FAIL dec_3fff: got sel=%b reg=%0d cart=%b expected 1/7/0", ppu_sel, ppu_reg, cart_sel); end
    n_checks++;
    if (rdata !== 8'hC3) begin n_fail++; $display("FAIL ppu_read: got %h expected c3", rdata); end
    cyc(16'h2000, 1'b1, 8'h80);
    n_checks++;
    if ({ppu_sel, ppu_reg, apu_sel} !== 5'b1_000_0) begin n_fail++; $display("FAIL dec_2000w: got sel=%b reg=%0d apu=%b expected 1/0/0", ppu_sel, ppu_reg, apu_sel); end
    cyc(16'h1FFF, 1'b0, 8'h00);
    n_checks++;
    if (ppu_sel !== 1'b0) begin n_fail++; $display("FAIL dec_1fff_ppu: got %b expected 0", ppu_sel); end
    n_checks++;
    if (rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_1fff: got %h expected a5", rdata); end
    cart_data = 8'h77;
    cyc(16'h4020, 1'b0, 8'h00);
    n_checks++;
    if (cart_sel !== 1'b1) begin n_fail++; $display("FAIL dec_4020: got %b expected 1", cart_sel); end
    n_checks++;
    if (rdata !== 8'h77) begin n_fail++; $display("FAIL cart_4020: got %h expected 77", rdata); end
    cyc(16'h401F, 1'b0, 8'h00);
    n_checks++;
    if (cart_sel !== 1'b0) begin n_fail++; $display("FAIL dec_401f: got %b expected 0", cart_sel); end
    cyc(16'hFFFF, 1'b0, 8'h00);
    n_checks++;
    if (cart_sel !== 1'b1) begin n_fail++; $display("FAIL dec_ffff: got %b expected 1", cart_sel); end
  endtask

  task automatic test_reset_mid;
    ctrl1 = 8'hFF;
    ctrl2 = 8'hFF;
    cyc(16'h4016, 1'b1, 8'h01);
    cyc(16'h4016, 1'b1, 8'h00);
    cyc(16'h4016, 1'b0, 8'h00);
    n_checks++;
    if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_bit: got %b expected 1", rdata[0]); end
    @(negedge clk);
    addr  = 16'h0123;
    rw    = 1'b1;
    wdata = 8'h11;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_async: got %h expected 00", rdata); end
    @(posedge clk);
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_hold: got %h expected 00", rdata); end
    @(negedge clk);
    addr  = 16'h4016;
    rw    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL post_reset_shift1: got %h expected 00", rdata); end
    cyc(16'h4017, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL post_reset_shift2: got %h expected 00", rdata); end
    cyc(16'h0123, 1'b0, 8'h00);
    n_checks++;
    if (rdata !== 8'h5A) begin n_fail++; $display("FAIL ram_survives_reset: got %h expected 5a", rdata); end
  endtask

  initial begin
    rst_n     = 1'b0;
    addr      = 16'h4016;
    rw        = 1'b0;
    wdata     = 8'h00;
    ppu_data  = 8'h00;
    cart_data = 8'h00;
    ctrl1     = 8'h00;
    ctrl2     = 8'h00;
    test_reset;
    test_ram_mirror;
    test_open_bus;
    test_controller;
    test_strobe_held;
    test_decode;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_bus_map.md
# cpu_bus_map

CPU-side address decoder and data-return stage for the NES core, sitting directly downstream of the 6502 bus master. It consumes the CPU's address, read/write strobe and write data, and serves internal 2 KB work RAM (mirrored) and both controller serial ports. It routes PPU ($2000–$3FFF), APU/IO and cartridge accesses to their owners and returns one registered read byte per bus cycle. An open-bus latch supplies undriven reads.

## Interface

Parameters:
- RAM_AW, 11, work-RAM address width (2 KB).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_address_i  in  16  CPU bus address.
- cpu_rw_i  in  1  1 = write, 0 = read (CPU convention).
- cpu_data_i  in  8  CPU write data.
- cpu_data_o  out  8  registered read data to CPU.
- ppu_sel_o  out  1  combinational; address in $2000–$3FFF.
- ppu_reg_o  out  3  cpu_address_i[2:0].
- ppu_data_i  in  8  PPU read data, valid combinationally while selected.
- apu_sel_o  out  1  combinational; write to $4000–$4013, $4015 or $4017.
- cart_sel_o  out  1  combinational; address in $4020–$FFFF.
- cart_data_i  in  8  cartridge read data.
- ctrl1_buttons_i  in  8  controller 1 live state, bit0=A,1=B,2=Select,3=Start,4=Up,5=Down,6=Left,7=Right; 1 = pressed.
- ctrl2_buttons_i  in  8  controller 2, same order.

## Operation

- Decode, with priority in the order listed:
  - $0000–$1FFF: work RAM at cpu_address_i[10:0], mirrored four times.
  - $2000–$3FFF: PPU.
  - $4016: controller 1 read / strobe write.
  - $4017: read controller 2; a write goes to the APU only.
  - $4020–$FFFF: cartridge.
  - All other addresses in $4000–$401F: reads are open bus; writes to them only drive apu_sel_o per the list above.
- RAM write: at the rising edge when cpu_rw_i=1; data = cpu_data_i. The RAM is single-port, inferred as block RAM. Its contents are not reset.
- Read return: at the rising edge when cpu_rw_i=0, cpu_data_o <= the selected source:
  - RAM[addr]
  - ppu_data_i
  - cart_data_i
  - the controller byte
  - open-bus latch
- Controller port byte: {open_bus[7:1], shift_n[0]}.
- Controller logic:
  - strobe_q is set by a write to $4016, taking cpu_data_i[0].
  - While strobe_q=1: shift1/shift2 reload from the button inputs every cycle. Reads return bit0 (A) and do not shift.
  - While strobe_q=0: a read of $4016/$4017 shifts the respective register right by one at the read edge, shifting in 1. After 8 reads, every further read returns 1 in bit0.
  - The 1→0 strobe edge leaves the last reloaded value in place.
- Open-bus latch, updated at every rising edge of a bus cycle:
  - read: takes the value written to cpu_data_o;
  - write: takes cpu_data_i.
- Write data is forwarded to the PPU, APU and cartridge via cpu_data_i; this block does not re-register it.
- OAM DMA cycles need no special handling: $2004 writes reach the PPU and source-page reads are served normally.

## Timing

- The CPU drives address, rw and write data on the falling clk edge. They are stable across the following rising edge, where this block commits.
- Read latency: cpu_data_o is valid from the rising edge of the access cycle until the next rising edge, so the CPU samples it on the next falling edge.
- The select outputs are combinational from the address. They are high for exactly the cycles the CPU spends on that address (one cycle per access), so PPU/cart read side effects fire once per CPU read.
- Reset values:
  - cpu_data_o = $00
  - open-bus latch = $00
  - strobe_q = 0
  - shift1 = shift2 = $00
- Reset asserted mid-access: the access is dropped and the registers return to their reset values immediately. A RAM write is committed only if the rising edge occurs with rst_n high.

## Configuration

- CPU_BUS_OPEN_BUS_EN.
  - Defined: open-bus latch implemented exactly as above.
  - Undefined: no latch. Unmapped reads return $00, and controller reads return {7'b0, shift_n[0]}.

## Test plan

- RAM mirror: write $5A to $0123, then read $0923, $1123 and $1923 → each returns $5A on cpu_data_o one rising edge after the access.
- Controller: ctrl1_buttons_i=$81, write $01 then $00 to $4016, then 10 reads of $4016:
  - bit0 sequence 1,0,0,0,0,0,0,1,1,1;
  - with the macro, upper bits equal the open-bus byte.
- Strobe held: $4016=1, toggle ctrl1 bit0 between reads → bit0 follows live A and there is no shifting. Controller 2 is independent: reading $4017 leaves shift1 unchanged.
- Open bus: read $4018 after reading $4A from the cartridge → $4A (with macro) or $00 (without).
- Decode: access $3FFF → ppu_sel_o=1 with ppu_reg_o=7. Access $4020 → cart_sel_o=1. Write $4017 → apu_sel_o=1 and strobe_q unchanged.
- Reset: deassert rst_n mid-controller-sequence → all outputs $00 and shift registers $00. RAM contents written before the reset survive.
